// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the universal shift register.
// Mode encodings and serializer state enum.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/univ_bit_cell.sv
// One bit of the universal shift register: 4:1 next-value mux
// plus flop with async active-low reset, sync set and enable.
module univ_bit_cell
  import shift_reg_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic       d,
  input  logic       r_in,
  input  logic       l_in,
  output logic       q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case (sel)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = r_in;
      MODE_SHL:  q_d = l_in;
      MODE_LOAD: q_d = d;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RST_VAL;
    end else if (set) begin
      q_q <= 1'b1;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with hold/shr/shl/load and an
// LSB-first serializer FSM reporting busy/done.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D_in,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          busy_q;
  logic          busy_d;
  logic          done_q;
  logic          done_d;

  logic [1:0]       eff_mode;
  logic [WIDTH-1:0] q_w;

  // The FSM overrides the external mode while loading or shifting.
  always_comb begin
    eff_mode = mode;
    unique case (1'b1)
      (state_q == IDLE) && start: eff_mode = MODE_LOAD;
      (state_q == SHIFT):         eff_mode = MODE_SHR;
      default:                    eff_mode = mode;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (set) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic r_in;
    logic l_in;

    if (i == WIDTH - 1) begin : g_msb
      assign r_in = sin_r;
    end else begin : g_mid_r
      assign r_in = q_w[i+1];
    end

    if (i == 0) begin : g_lsb
      assign l_in = sin_l;
    end else begin : g_mid_l
      assign l_in = q_w[i-1];
    end

    univ_bit_cell #(
      .RST_VAL(RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .set  (set),
      .en   (enable),
      .sel  (eff_mode),
      .d    (D_in[i]),
      .r_in (r_in),
      .l_in (l_in),
      .q    (q_w[i])
    );
  end

  assign Q      = q_w;
  assign sout_r = q_w[0];
  assign sout_l = q_w[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ against a
// behavioural model: directed scenarios then random traffic.
module tb_shift_reg_univ;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         set;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] d_in;
  logic         sin_r;
  logic         sin_l;
  logic         start;
  logic [W-1:0] q;
  logic         sout_r;
  logic         sout_l;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Model: word value, bits still to stream, done-cycle flag.
  logic [W-1:0] m_q;
  int           m_left;
  bit           m_done;

  always #5 clk = ~clk;

  shift_reg_univ #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .set   (set),
    .enable(enable),
    .mode  (mode),
    .D_in  (d_in),
    .sin_r (sin_r),
    .sin_l (sin_l),
    .start (start),
    .Q     (q),
    .sout_r(sout_r),
    .sout_l(sout_l),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("q", 32'(q), 32'(m_q));
    chk("sout_r", 32'(sout_r), 32'(m_q[0]));
    chk("sout_l", 32'(sout_l), 32'(m_q[W-1]));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic model_reset();
    m_q    = '0;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic model_mode();
    case (mode)
      2'd1: m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
      2'd2: m_q = (m_q << 1) | W'(sin_l);
      2'd3: m_q = d_in;
      default: m_q = m_q;
    endcase
  endtask

  task automatic model_edge();
    if (set) begin
      m_q    = '1;
      m_left = 0;
      m_done = 1'b0;
    end else if (enable) begin
      if (m_done) begin
        m_done = 1'b0;
        model_mode();
      end else if (m_left > 0) begin
        m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (start) begin
        m_q    = d_in;
        m_left = W;
      end else begin
        model_mode();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    chk_all();
  endtask

  task automatic drv(input logic s, input logic e,
                     input logic [1:0] md,
                     input logic [W-1:0] d,
                     input logic sr, input logic sl,
                     input logic st);
    set    = s;
    enable = e;
    mode   = md;
    d_in   = d;
    sin_r  = sr;
    sin_l  = sl;
    start  = st;
  endtask

  initial begin
    logic [W-1:0] seq;
    logic [5:0]   sq;
    logic [6:0]   bz;
    logic [6:0]   dn;
    int           nb;
    int           nd;

    reset = 1'b0;
    drv(0, 1, 2'd0, '0, 0, 0, 0);
    model_reset();
    #1;
    chk_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Mode operations
    drv(0, 1, 2'd3, 4'b1011, 0, 0, 0);
    tick();
    chk("load", 32'(q), 32'hB);
    drv(0, 1, 2'd1, '0, 0, 0, 0);
    tick();
    chk("shr", 32'(q), 32'h5);
    drv(0, 1, 2'd2, '0, 0, 1, 0);
    tick();
    chk("shl", 32'(q), 32'hB);
    drv(0, 1, 2'd0, '0, 0, 0, 0);
    repeat (3) tick();
    chk("hold", 32'(q), 32'hB);

    // Serialize
    drv(0, 1, 2'd0, 4'b1101, 0, 0, 1);
    tick();
    start = 1'b0;
    nb    = 0;
    for (int k = 0; k < W; k++) begin
      seq[k] = sout_r;
      nb += int'(busy);
      tick();
    end
    chk("ser_bits", 32'(seq), 32'hD);
    chk("ser_busy", 32'(nb), 32'd4);
    chk("ser_done", 32'(done), 32'd1);
    chk("ser_q", 32'(q), 32'h0);
    tick();

    // Enable stall after the second bit
    drv(0, 1, 2'd0, 4'b1101, 0, 0, 1);
    tick();
    start = 1'b0;
    nb    = 0;
    for (int c = 0; c < 6; c++) begin
      sq[c] = sout_r;
      nb += int'(busy);
      enable = !(c == 1 || c == 2);
      tick();
    end
    enable = 1'b1;
    chk("stall_bits", 32'(sq), 32'(6'b110001));
    chk("stall_busy", 32'(nb), 32'd6);
    chk("stall_done", 32'(done), 32'd1);
    tick();

    // Abort on third shift cycle
    drv(0, 1, 2'd0, 4'b1101, 0, 0, 1);
    tick();
    start = 1'b0;
    repeat (2) tick();
    set = 1'b1;
    tick();
    set = 1'b0;
    chk("abort_q", 32'(q), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);
    nd = 0;
    repeat (5) begin
      tick();
      nd += int'(done);
    end
    chk("abort_nodone", 32'(nd), 32'd0);

    // Set together with start in IDLE
    drv(1, 1, 2'd0, 4'b0101, 0, 0, 1);
    tick();
    drv(0, 1, 2'd0, 4'b0101, 0, 0, 0);
    chk("setstart_q", 32'(q), 32'hF);
    tick();
    chk("setstart_busy", 32'(busy), 32'd0);

    // Start held high through SHIFT and DONE
    drv(0, 1, 2'd0, 4'b1101, 0, 0, 1);
    tick();
    d_in = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      bz[c] = busy;
      dn[c] = done;
      if (c < 6) tick();
    end
    chk("hold_start_busy", 32'(bz), 32'(7'b1001111));
    chk("hold_start_done", 32'(dn), 32'(7'b0010000));
    chk("hold_start_q", 32'(q), 32'hA);
    start = 1'b0;
    repeat (6) tick();

    // Start with SHR in IDLE: load wins
    drv(0, 1, 2'd1, 4'b0110, 1, 0, 1);
    tick();
    start = 1'b0;
    chk("start_shr_q", 32'(q), 32'h6);
    chk("start_shr_busy", 32'(busy), 32'd1);
    repeat (6) tick();

    // Async reset mid-serialize
    drv(0, 1, 2'd0, 4'b1101, 0, 0, 1);
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("arst_idle", 32'(busy), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drv($urandom_range(0, 31) == 0,
          $urandom_range(0, 4) != 0,
          2'($urandom_range(0, 3)),
          W'($urandom),
          1'($urandom),
          1'($urandom),
          $urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register used as the RAM_16x4 storage word. It provides hold, shift right, shift left and parallel load over a WIDTH-bit word, plus a built-in serializer FSM that loads a word and streams it out LSB-first with busy/done status. It sits between the RAM data path and serial links or test logic that need word-to-bit conversion.

## Interface
- WIDTH, 4, word width in bits; legal range ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}, value forced onto Q by reset.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- set  in  1  synchronous; drives Q to all ones and aborts serialization.
- enable  in  1  clock enable for the whole block, including Q, FSM and counter.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D_in  in  WIDTH  parallel load data.
- sin_r  in  1  serial input on right shift; enters Q[WIDTH-1].
- sin_l  in  1  serial input on left shift; enters Q[0].
- start  in  1  begins a serialize operation; level-sampled.
- Q  out  WIDTH  register contents.
- sout_r  out  1  equals Q[0]; this is the serialize output.
- sout_l  out  1  equals Q[WIDTH-1].
- busy  out  1  high while serializing.
- done  out  1  one-state pulse marking serialize completion.

## Operation
- Reset (reset=0): Q=RESET_VAL, state=IDLE, cnt=0, busy=0, done=0. Takes effect immediately, including mid-serialize. No done pulse is generated.
- Priority at each rising edge: set > enable=0 (freeze) > FSM (start/busy) > mode.
- set=1: Q=all ones, state=IDLE, cnt=0. Applies regardless of enable. An in-flight serialize aborts with no done pulse.
- enable=0: Q, state and cnt all hold, and outputs hold.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE with start=1: Q←D_in, cnt←0, go to SHIFT. start beats mode.
  - IDLE with start=0: mode applies.
  - SHIFT: each enabled edge performs a right shift with sin_r and increments cnt. At the edge where cnt==WIDTH-1, go to DONE. mode and start are ignored.
  - DONE: one enabled cycle, then IDLE. mode applies normally in this state. start in DONE is ignored; a new start is accepted only in IDLE.
- busy=1 exactly in SHIFT; done=1 exactly in DONE.
- Serialize output: during SHIFT cycle k (k=0..WIDTH-1), sout_r = loaded D_in[k]. After completion, Q holds the WIDTH captured sin_r bits, the first captured bit in Q[0].
- Shift right: Q←{sin_r, Q[WIDTH-1:1]}.
- Shift left: Q←{Q[WIDTH-2:0], sin_l}.
- cnt width is $clog2(WIDTH). Comparison is against WIDTH-1 only, so wrap-around cannot occur.

## Timing
- Q, busy and done are registered. sout_r and sout_l are combinational from Q.
- Mode operations have a latency of 1 edge.
- Serialize sequence, counting from the start-sampling edge E0:
  - busy rises after E0 and stays high for WIDTH enabled cycles.
  - done is high for the enabled cycle after that.
  - The next start is accepted WIDTH+2 enabled edges after E0.
- An enable-low cycle stretches every phase by one cycle; no bit is lost or duplicated.
- Asynchronous reset assertion clears outputs without a clock. Deassertion is assumed synchronous to clk by the upstream reset synchronizer.

## Structure
- Package shift_reg_pkg holds:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - the state enum (IDLE, SHIFT, DONE).
- Sub-module univ_bit_cell: one bit, consisting of a 4:1 next-value mux (hold/right-neighbour/left-neighbour/D) plus a flip-flop with async active-low reset, sync set and enable. It is instantiated WIDTH times by generate.
- The top level holds the FSM, cnt and the effective-mode decode (FSM overrides mode).

## Test plan
- Reset: assert reset=0 mid-serialize (WIDTH=4, D_in=4'b1101) → Q=0000, busy=0 and done=0 without a clock edge; release reset and remain IDLE.
- Mode ops: load 4'b1011 → Q=1011; SHR with sin_r=0 → 0101; SHL with sin_l=1 → 1011; hold for 3 cycles → 1011 unchanged.
- Serialize: D_in=4'b1101, start=1 for one cycle, sin_r=0 →
  - sout_r = 1,0,1,1 over the next 4 cycles, with busy high for those 4 cycles.
  - done pulses on cycle 5; Q=0000 afterwards.
- Enable stall: same as the serialize scenario, but enable=0 for 2 cycles after the second bit → bit sequence 1,0,1,1 unbroken, busy high for 6 cycles, done delayed by 2 cycles.
- Abort: set=1 on the third SHIFT cycle → Q=1111, busy=0 next cycle, no done pulse. set and start together in IDLE → Q=1111 and no serialization.
- Start collisions:
  - start held high through SHIFT and DONE → ignored until IDLE; the new load occurs one edge after DONE.
  - start together with mode=SHR in IDLE → the load wins.
